// File: rtl/flash_bus_bridge_pkg.sv
// Shared definitions for the CPU-bus to SPI-flash read bridge:
// FSM states, default window decode, timeout limits and fill value.
package flash_bus_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        HOLD
    } state_t;

    localparam logic [15:0] DEFAULT_ROM_BASE       = 16'hC000;
    localparam logic [15:0] DEFAULT_ROM_MASK       = 16'hC000;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int unsigned DEFAULT_SYNC_STAGES    = 2;
    localparam logic [7:0]  TIMEOUT_FILL           = 8'hFF;

    function automatic logic in_window(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input logic [15:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/flash_bus_bridge_e_clk_sync.sv
// Synchronizes the CPU E clock into the clk domain and emits one-clk
// registered rise/fall event pulses.
module e_clk_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic e_async,
    output logic e_rise,
    output logic e_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   e_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            e_prev <= 1'b0;
            e_rise <= 1'b0;
            e_fall <= 1'b0;
        end else begin
            sync_q[0] <= e_async;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            e_prev <= sync_q[SYNC_STAGES-1];
            e_rise <= sync_q[SYNC_STAGES-1] & ~e_prev;
            e_fall <= ~sync_q[SYNC_STAGES-1] & e_prev;
        end
    end

endmodule

// File: rtl/flash_bus_bridge.sv
// CPU-side front end for spi_flash_controller: decodes ROM-window reads,
// stretches the CPU with MRDY on a miss and serves repeats from a one-entry buffer.
module flash_bus_bridge
    import flash_bus_bridge_pkg::*;
#(
    parameter logic [15:0] ROM_BASE       = DEFAULT_ROM_BASE,
    parameter logic [15:0] ROM_MASK       = DEFAULT_ROM_MASK,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned SYNC_STAGES    = DEFAULT_SYNC_STAGES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_ADDRESS_BUS,
    input  logic        i_RW,
    input  logic        i_VMA,
    input  logic        i_E,
    output logic        o_MRDY,
    output logic [7:0]  o_DATA,
    output logic        o_DATA_OE,
    output logic        o_spi_ce,
    output logic [15:0] o_spi_addr,
    input  logic [7:0]  i_spi_data,
    input  logic        i_MemoryReady,
    output logic        o_timeout
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state;
    logic        e_rise;
    logic        e_fall;
    logic        qualifying;
    logic        buf_valid;
    logic [15:0] buf_addr;
    logic [7:0]  buf_data;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_next;

    e_clk_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_e_sync (
        .clk    (clk),
        .reset  (reset),
        .e_async(i_E),
        .e_rise (e_rise),
        .e_fall (e_fall)
    );

    always_comb begin
        qualifying    = e_rise && i_VMA && i_RW && in_window(i_ADDRESS_BUS, ROM_BASE, ROM_MASK);
        wait_cnt_next = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            o_MRDY     <= 1'b1;
            o_DATA     <= '0;
            o_DATA_OE  <= 1'b0;
            o_spi_ce   <= 1'b0;
            o_spi_addr <= '0;
            o_timeout  <= 1'b0;
            buf_valid  <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (qualifying) begin
                        if (buf_valid && (i_ADDRESS_BUS == buf_addr)) begin
                            o_DATA    <= buf_data;
                            o_DATA_OE <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            o_spi_addr <= i_ADDRESS_BUS;
                            o_MRDY     <= 1'b0;
                            wait_cnt   <= '0;
                            state      <= START;
                        end
                    end
                end
                // Hold off the request until the previous transfer's ready has dropped.
                START: begin
                    if (!i_MemoryReady) begin
                        o_spi_ce <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt_next;
                    if (i_MemoryReady) begin
                        o_DATA    <= i_spi_data;
                        buf_addr  <= o_spi_addr;
                        buf_data  <= i_spi_data;
                        buf_valid <= 1'b1;
                        o_spi_ce  <= 1'b0;
                        o_MRDY    <= 1'b1;
                        o_DATA_OE <= 1'b1;
                        state     <= HOLD;
                    end else if (wait_cnt_next == TIMEOUT_LIMIT) begin
                        o_DATA    <= TIMEOUT_FILL;
                        o_timeout <= 1'b1;
                        buf_valid <= 1'b0;
                        o_spi_ce  <= 1'b0;
                        o_MRDY    <= 1'b1;
                        o_DATA_OE <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (e_fall) begin
                        o_DATA_OE <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
